// File: rtl/switch_conditioner.sv
// Push-button conditioner: two-flop synchronizer, counter debounce, press/release
// pulses and a hold FSM that produces long-press and auto-repeat step requests.
module switch_conditioner #(
    parameter int DEBOUNCE_LIMIT   = 250000,
    parameter int LONG_PRESS_LIMIT = 12500000,
    parameter int REPEAT_LIMIT     = 2500000
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Level,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long,
    output logic o_Step
);

    localparam int DB_W     = (DEBOUNCE_LIMIT > 2) ? $clog2(DEBOUNCE_LIMIT) : 1;
    localparam int HOLD_MAX = (LONG_PRESS_LIMIT > REPEAT_LIMIT) ? LONG_PRESS_LIMIT : REPEAT_LIMIT;
    localparam int HOLD_W   = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_PRESS_LIMIT - 1);
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } hold_state_e;

    logic              sync1_q, sync2_q;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              rise, fall;
    hold_state_e       state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_q, long_d;
    logic              step_q, step_d;

    // Debounce: any agreement between sync and the level restarts the count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        db_cnt_d  = '0;
        level_d   = level_q;
        rise      = 1'b0;
        fall      = 1'b0;
        if (sync2_q != level_q) begin
            if (db_cnt_q == DB_LAST) begin
                level_d = sync2_q;
                rise    = sync2_q;
                fall    = ~sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
        press_d   = rise;
        release_d = fall;
    end

    // Hold FSM: a release edge always wins over a due long/repeat step.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        long_d     = long_q;
        step_d     = 1'b0;
        case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                long_d     = 1'b0;
                if (rise) begin
                    state_d = HELD;
                    step_d  = 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    long_d     = 1'b0;
                end else if (hold_cnt_q == LONG_LAST) begin
                    state_d    = REPEAT;
                    hold_cnt_d = '0;
                    long_d     = 1'b1;
                    step_d     = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                    long_d     = 1'b0;
                end else if (hold_cnt_q == REP_LAST) begin
                    hold_cnt_d = '0;
                    step_d     = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d    = IDLE;
                hold_cnt_d = '0;
                long_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (i_Reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            db_cnt_q   <= '0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
            step_q     <= 1'b0;
        end else begin
            sync1_q    <= i_Switch;
            sync2_q    <= sync1_q;
            db_cnt_q   <= db_cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
            step_q     <= step_d;
        end
    end

    assign o_Level   = level_q;
    assign o_Press   = press_q;
    assign o_Release = release_q;
    assign o_Long    = long_q;
    assign o_Step    = step_q;

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter DEBOUNCE_LIMIT, default 250000, is the number of stable cycles required before the debounced level changes.
REQ-002 Parameter LONG_PRESS_LIMIT, default 12500000, is the number of cycles from press to long-press detection.
REQ-003 Parameter REPEAT_LIMIT, default 2500000, is the number of cycles between auto-repeat steps.
REQ-004 i_Clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_Reset  input  1  synchronous, active-high reset.
REQ-006 i_Switch  input  1  raw push-button level, asynchronous and bouncing; 1 = pressed.
REQ-007 o_Level  output  1  debounced switch level.
REQ-008 o_Press  output  1  one-cycle pulse on each debounced 0->1 transition.
REQ-009 o_Release  output  1  one-cycle pulse on each debounced 1->0 transition.
REQ-010 o_Long  output  1  high while the press has lasted at least LONG_PRESS_LIMIT cycles.
REQ-011 o_Step  output  1  one-cycle increment request: press pulse plus auto-repeat pulses; drives the downstream counter/display stage.

Function
REQ-012 i_Switch SHALL pass through a 2-flop synchronizer; only the second flop's output (sync) feeds further logic.
REQ-013 Debounce counter SHALL clear whenever sync equals o_Level, and increment by 1 otherwise.
REQ-014 When the counter equals DEBOUNCE_LIMIT-1 and sync differs from o_Level, o_Level SHALL take the sync value on that edge and the counter SHALL clear.
REQ-015 Latency: o_Level SHALL change on the (DEBOUNCE_LIMIT+2)th rising edge counting the edge that first samples the new stable i_Switch value as edge 1.
REQ-016 A sync deviation shorter than DEBOUNCE_LIMIT cycles SHALL leave o_Level unchanged.
REQ-017 o_Press and o_Release SHALL be registered and asserted in the same cycle o_Level first shows the new value, for exactly one cycle.
REQ-018 The hold FSM SHALL have states IDLE, HELD and REPEAT, with a hold counter of width clog2(max(LONG_PRESS_LIMIT, REPEAT_LIMIT)).
REQ-019 IDLE->HELD on the press edge: o_Step pulses with o_Press, and the hold counter clears.
REQ-020 HELD: the hold counter increments each cycle; at LONG_PRESS_LIMIT cycles after o_Press -> REPEAT, o_Long rises, o_Step pulses, and the counter clears.
REQ-021 REPEAT: o_Long stays high; o_Step pulses every REPEAT_LIMIT cycles after the previous o_Step.
REQ-022 From HELD or REPEAT, the release edge SHALL transition to IDLE in the same cycle: o_Long falls, the hold counter clears, no o_Step is issued.
REQ-023 A release coinciding with a due long or repeat event SHALL win: no o_Step, and o_Long is not set.
REQ-024 o_Press and o_Release SHALL never assert in the same cycle; o_Step SHALL never assert in IDLE except with o_Press.
REQ-025 All parameters SHALL be >= 2, and counters SHALL not wrap: they saturate or clear per the rules above.

Reset
REQ-026 With i_Reset high at an edge, synchronizer flops, o_Level, o_Press, o_Release, o_Long, o_Step and both counters SHALL be 0, and the FSM SHALL be IDLE.
REQ-027 Reset mid-operation SHALL abandon any press; a switch still held after reset SHALL be treated as a new press after the full debounce latency.
REQ-028 i_Reset SHALL override all other events on the same edge.

Verification (DEBOUNCE_LIMIT=4, LONG_PRESS_LIMIT=20, REPEAT_LIMIT=5)
REQ-029 The bench SHALL cover a clean press: i_Switch 0->1 first sampled on edge 1 -> o_Level, o_Press and o_Step high on edge 6, with o_Press and o_Step low on edge 7.
REQ-030 The bench SHALL cover bounce: i_Switch toggles high for 3 cycles, low for 2 cycles, then stays high -> exactly one o_Press, 6 edges after the final rise is sampled.
REQ-031 The bench SHALL cover a long hold: held after o_Press at edge P -> o_Long and o_Step at P+20, o_Step at P+25, P+30 and P+35; no other o_Step.
REQ-032 The bench SHALL cover release during repeat: release raw at a time where the debounced fall lands on P+30 -> o_Release at P+30, o_Long low at P+30, no o_Step at P+30 or after.
REQ-033 The bench SHALL cover reset mid-hold: i_Reset for 1 cycle at P+22 with the switch held -> all outputs 0 on that edge, then o_Press 6 edges after reset deasserts.
REQ-034 The bench SHALL cover a short press: i_Switch high for 10 cycles -> o_Press, o_Step, then o_Release; o_Long never asserts.
